// File: rtl/filter2d_pkg.sv
// Shared constants and reader FSM encoding for the filter2d memory datapath.
package filter2d_pkg;

   localparam int unsigned IMG_W    = 256;
   localparam int unsigned IMG_H    = 256;
   localparam int unsigned OUT_BASE = 65536;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StRun   = 2'd1,
      StDrain = 2'd2,
      StDone  = 2'd3
   } rd_state_e;

endpackage

// File: rtl/stream_fifo2.sv
// Two-entry FIFO with registered head output; head_q is always the oldest entry.
module stream_fifo2 #(
   parameter int unsigned EW = 10
) (
   input  logic          clk_i,
   input  logic          n_reset_i,
   input  logic          push_i,
   input  logic [EW-1:0] data_i,
   input  logic          pop_i,
   output logic [1:0]    count_o,
   output logic [EW-1:0] data_o,
   output logic          valid_o
);

   logic [EW-1:0] head_q, head_d;
   logic [EW-1:0] tail_q, tail_d;
   logic [1:0]    count_q, count_d;
   logic          pop_ok;

   assign pop_ok = pop_i && (count_q != 2'd0);

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      case ({push_i, pop_ok})
         2'b10: begin
            if (count_q == 2'd0) begin
               head_d  = data_i;
               count_d = 2'd1;
            end else if (count_q == 2'd1) begin
               tail_d  = data_i;
               count_d = 2'd2;
            end
         end
         2'b01: begin
            head_d  = tail_q;
            count_d = count_q - 2'd1;
         end
         2'b11: begin
            // Simultaneous push/pop keeps the count; new data lands behind any remaining entry.
            if (count_q == 2'd1) begin
               head_d = data_i;
            end else begin
               head_d = tail_q;
               tail_d = data_i;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i or negedge n_reset_i) begin
      if (!n_reset_i) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= 2'd0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   assign count_o = count_q;
   assign data_o  = head_q;
   assign valid_o = (count_q != 2'd0);

endmodule

// File: rtl/frame_mem_reader.sv
// Reads a WIDTH x HEIGHT frame from a 1-cycle-latency memory and streams it out in raster order.
module frame_mem_reader
   import filter2d_pkg::*;
#(
   parameter int unsigned WIDTH  = IMG_W,
   parameter int unsigned HEIGHT = IMG_H,
   parameter int unsigned AW     = 17,
   parameter int unsigned DW     = 8,
   parameter int unsigned BASE   = OUT_BASE
) (
   input  logic          clk,
   input  logic          n_reset,
   input  logic          start,
   output logic          busy,
   output logic          finish,
   output logic          cs,
   output logic          we,
   output logic [AW-1:0] addr,
   output logic [DW-1:0] din,
   input  logic [DW-1:0] dout,
   output logic          m_valid,
   input  logic          m_ready,
   output logic [DW-1:0] m_data,
   output logic          m_eol,
   output logic          m_eof
);

   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int unsigned RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
   localparam int unsigned EW = DW + 2;

   rd_state_e     state_q, state_d;
   logic [CW-1:0] col_q, col_d;
   logic [RW-1:0] row_q, row_d;
   logic [AW-1:0] ptr_q, ptr_d;
   logic          inflight_q, inflight_d;
   logic          eol_tag_q, eol_tag_d;
   logic          eof_tag_q, eof_tag_d;

   logic          last_col, last_row;
   logic          pop;
   logic [1:0]    fifo_count;
   logic [2:0]    credit;
   logic [EW-1:0] fifo_head;
   logic          fifo_valid;

   assign last_col = (col_q == CW'(WIDTH - 1));
   assign last_row = (row_q == RW'(HEIGHT - 1));
   assign pop      = fifo_valid && m_ready;

   // Entries held or still in flight after this cycle's pop; a read is issued only if room remains.
   assign credit = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};
   assign cs     = (state_q == StRun) && (credit < 3'd2);

   always_comb begin
      state_d    = state_q;
      col_d      = col_q;
      row_d      = row_q;
      ptr_d      = ptr_q;
      eol_tag_d  = eol_tag_q;
      eof_tag_d  = eof_tag_q;
      inflight_d = cs;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StRun;
               col_d   = '0;
               row_d   = '0;
               ptr_d   = AW'(BASE);
            end
         end
         StRun: begin
            if (cs) begin
               ptr_d     = ptr_q + 1'b1;
               eol_tag_d = last_col;
               eof_tag_d = last_col && last_row;
               if (last_col) begin
                  col_d = '0;
                  row_d = row_q + 1'b1;
                  if (last_row) begin
                     state_d = StDrain;
                  end
               end else begin
                  col_d = col_q + 1'b1;
               end
            end
         end
         StDrain: begin
            if (pop && m_eof) begin
               state_d = StDone;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         state_q    <= StIdle;
         col_q      <= '0;
         row_q      <= '0;
         ptr_q      <= '0;
         inflight_q <= 1'b0;
         eol_tag_q  <= 1'b0;
         eof_tag_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         col_q      <= col_d;
         row_q      <= row_d;
         ptr_q      <= ptr_d;
         inflight_q <= inflight_d;
         eol_tag_q  <= eol_tag_d;
         eof_tag_q  <= eof_tag_d;
      end
   end

   stream_fifo2 #(
      .EW(EW)
   ) u_fifo (
      .clk_i    (clk),
      .n_reset_i(n_reset),
      .push_i   (inflight_q),
      .data_i   ({eof_tag_q, eol_tag_q, dout}),
      .pop_i    (pop),
      .count_o  (fifo_count),
      .data_o   (fifo_head),
      .valid_o  (fifo_valid)
   );

   assign busy    = (state_q != StIdle);
   assign finish  = (state_q == StDone);
   assign we      = 1'b0;
   assign din     = '0;
   assign addr    = ptr_q;
   assign m_valid = fifo_valid;
   assign m_data  = fifo_head[DW-1:0];
   assign m_eol   = fifo_head[DW];
   assign m_eof   = fifo_head[DW+1];

endmodule

// File: tb/tb_frame_mem_reader.sv
// Scoreboard bench: expected addresses/beats queued at start, monitor compares on cs and handshakes.
module tb_frame_mem_reader;

   localparam int unsigned W    = 8;
   localparam int unsigned H    = 4;
   localparam int unsigned N    = W * H;
   localparam int unsigned AW   = 17;
   localparam int unsigned DW   = 8;
   localparam int unsigned BASE = 17'h1FFF0;

   typedef struct packed {
      logic          eof;
      logic          eol;
      logic [DW-1:0] data;
   } beat_t;

   logic          clk;
   logic          n_reset;
   logic          start;
   logic          busy, finish, cs, we;
   logic [AW-1:0] addr;
   logic [DW-1:0] din, dout;
   logic          m_valid, m_ready, m_eol, m_eof;
   logic [DW-1:0] m_data;

   logic [DW-1:0] mem [0:(1<<AW)-1];
   logic [AW-1:0] addr_q [$];
   beat_t         exp_q [$];

   int errs = 0;
   int checks = 0;
   int cyc = 0;
   int beats = 0;
   int fin_cnt = 0;
   int out_cnt = 0;
   int ready_mode = 0;
   logic  prev_stall = 1'b0;
   beat_t prev_beat = '0;

   frame_mem_reader #(
      .WIDTH (W),
      .HEIGHT(H),
      .AW    (AW),
      .DW    (DW),
      .BASE  (BASE)
   ) dut (
      .clk    (clk),
      .n_reset(n_reset),
      .start  (start),
      .busy   (busy),
      .finish (finish),
      .cs     (cs),
      .we     (we),
      .addr   (addr),
      .din    (din),
      .dout   (dout),
      .m_valid(m_valid),
      .m_ready(m_ready),
      .m_data (m_data),
      .m_eol  (m_eol),
      .m_eof  (m_eof)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Memory model: one-cycle read latency.
   always @(posedge clk) if (cs) dout <= mem[addr];

   always @(posedge clk) begin
      #1;
      case (ready_mode)
         0: m_ready = 1'b1;
         1: m_ready = 1'($urandom_range(0, 1));
         default: m_ready = 1'b0;
      endcase
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h, required %0h (time %0t)", name, act, exp, $time);
      end
   endtask

   task automatic fail(input string name);
      checks++;
      errs++;
      $display("FAIL %s: got no event, required one (time %0t)", name, $time);
   endtask

   always @(negedge clk) begin
      beat_t cur;
      beat_t e;
      logic [AW-1:0] a;
      cur = {m_eof, m_eol, m_data};
      if (!n_reset) begin
         out_cnt    = 0;
         prev_stall = 1'b0;
      end else begin
         if (finish) fin_cnt++;
         if (prev_stall) chk("stall_hold", 32'({m_valid, cur}), 32'({1'b1, prev_beat}));
         if (cs) begin
            chk("we_din_zero", 32'({we, din}), 32'd0);
            if (addr_q.size() == 0) begin
               fail("unexpected_read");
            end else begin
               a = addr_q.pop_front();
               chk("addr", 32'(addr), 32'(a));
            end
            out_cnt++;
         end
         if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
               fail("unexpected_beat");
            end else begin
               e = exp_q.pop_front();
               chk("beat", 32'(cur), 32'(e));
            end
            beats++;
            out_cnt--;
         end
         if (cs) chk("outstanding_le2", 32'(out_cnt <= 2), 32'd1);
         prev_stall = m_valid && !m_ready;
         prev_beat  = cur;
      end
   end

   // Reference: beat i of a frame reads word (BASE + i) mod 2^AW in raster order.
   task automatic push_frame_expect();
      logic [AW-1:0] a;
      beat_t b;
      for (int i = 0; i < int'(N); i++) begin
         a      = AW'(BASE + i);
         b.data = mem[a];
         b.eol  = ((i % W) == W - 1);
         b.eof  = (i == N - 1);
         addr_q.push_back(a);
         exp_q.push_back(b);
      end
   endtask

   task automatic do_start(output int st_cyc);
      @(posedge clk);
      #1;
      start = 1'b1;
      push_frame_expect();
      @(posedge clk);
      #1;
      st_cyc = cyc;
      start  = 1'b0;
   endtask

   task automatic wait_finish(output int fin_cyc);
      int n;
      n       = 0;
      fin_cyc = -1;
      while (n < int'(N * 6 + 50)) begin
         @(negedge clk);
         n++;
         if (finish) begin
            fin_cyc = cyc;
            break;
         end
      end
      if (fin_cyc < 0) fail("finish_timeout");
   endtask

   task automatic wait_beats(input int target);
      int n;
      n = 0;
      while (beats < target && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (beats < target) fail("beat_timeout");
   endtask

   task automatic settle();
      repeat (3) @(negedge clk);
      chk("queues_empty", 32'(exp_q.size() + addr_q.size()), 32'd0);
      chk("idle_after_frame", 32'({busy, cs, m_valid}), 32'd0);
   endtask

   task automatic check_zero(input string name);
      chk({name, "_ctl"}, 32'({busy, finish, cs, we, m_valid, m_eol, m_eof}), 32'd0);
      chk({name, "_addr"}, 32'(addr), 32'd0);
      chk({name, "_data"}, 32'({din, m_data}), 32'd0);
   endtask

   initial begin
      int s, f, fc0;
      n_reset = 1'b0;
      start   = 1'b0;
      m_ready = 1'b0;
      dout    = '0;
      for (int i = 0; i < (1 << AW); i++) mem[i] = 8'($urandom);

      repeat (3) @(posedge clk);
      #1;
      check_zero("reset");
      @(posedge clk);
      #2 n_reset = 1'b1;

      // Full-rate frame with address wrap past 2^AW-1.
      ready_mode = 0;
      do_start(s);
      wait_finish(f);
      chk("frame_latency", 32'(f - s), 32'(N + 2));
      settle();

      // Random back-pressure.
      ready_mode = 1;
      repeat (3) begin
         do_start(s);
         wait_finish(f);
         settle();
      end

      // Mid-row stall: reads must stop with two outstanding, stream resumes without bubbles.
      ready_mode = 0;
      do_start(s);
      wait_beats(beats + 10);
      ready_mode = 2;
      @(posedge clk);
      repeat (9) @(posedge clk);
      @(negedge clk);
      chk("stall_cs_off", 32'(cs), 32'd0);
      chk("stall_valid", 32'(m_valid), 32'd1);
      @(posedge clk);
      ready_mode = 0;
      repeat (4) begin
         @(negedge clk);
         chk("resume_valid", 32'({m_valid, m_ready}), 32'd3);
      end
      wait_finish(f);
      settle();

      // start pulses in RUN and in DONE are ignored.
      fc0 = fin_cnt;
      do_start(s);
      wait_beats(beats + 5);
      @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      wait_finish(f);
      chk("frame_latency_restart", 32'(f - s), 32'(N + 2));
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      settle();
      chk("one_finish", 32'(fin_cnt - fc0), 32'd1);

      // Asynchronous reset mid-frame aborts it.
      do_start(s);
      wait_beats(beats + 10);
      @(posedge clk);
      #2 n_reset = 1'b0;
      #1;
      check_zero("midreset");
      exp_q.delete();
      addr_q.delete();
      fc0 = fin_cnt;
      repeat (3) @(posedge clk);
      #2 n_reset = 1'b1;
      repeat (5) @(negedge clk);
      chk("no_finish_after_reset", 32'(fin_cnt - fc0), 32'd0);
      do_start(s);
      wait_finish(f);
      chk("frame_latency_after_reset", 32'(f - s), 32'(N + 2));
      settle();

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
